data_mem_ctrl: RTL and testbench
================================

Name: data_mem_ctrl

Overview:
- Parametrised data-memory block for the MEM stage of the pipelined core.
- Supersedes the fixed word-only memory. Adds configurable base, depth and wait states, and byte/halfword/word access with sign extension.
- Adds alignment and range checking, plus a stall output that freezes upstream stages during wait states.
- Byte-addressed, big-endian: the lowest address holds the MSB.

Parameters:
- ADDR_BASE, 1024: first valid byte address; local index = adr - ADDR_BASE.
- DEPTH_BYTES, 1024: memory size in bytes; must be a power of two and at least 4.
- WAIT_STATES, 0: extra cycles an access is held before it completes; range 0..15.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- mem_r_en  in  1  read request.
- mem_w_en  in  1  write request.
- size  in  2  access size: 00 = byte, 01 = halfword, 10 = word, 11 = reserved (error).
- sign_ext  in  1  reads only: sign-extend byte/halfword when 1, zero-extend when 0.
- adr  in  32  byte address.
- data_in  in  32  write data; byte/halfword taken from the low bits.
- rdata  out  32  registered read data.
- done  out  1  one-cycle pulse after an access completes (read or write).
- stall  out  1  combinational; high while an accepted access has not yet completed.
- err  out  1  one-cycle pulse with done when the access was illegal.

Behaviour:
- Reset (rst = 0, asynchronous):
  - rdata = 0, done = 0, err = 0, FSM = IDLE, wait counter = 0.
  - stall is forced to 0.
  - Memory contents are not cleared.
- Request definition: req = mem_r_en | mem_w_en.
  - When both are set, the read takes priority and no write occurs.
  - The requester holds adr, size, data_in and both enables stable while stall = 1.
- FSM states: IDLE, WAIT.
- IDLE with req and WAIT_STATES = 0:
  - The access is performed at the current edge; the FSM stays in IDLE.
  - done (and err, if illegal) is high the following cycle; stall is never asserted.
- IDLE with req and WAIT_STATES > 0:
  - stall = 1 combinationally in that cycle.
  - At the edge: FSM -> WAIT, counter = 1.
- WAIT:
  - While counter < WAIT_STATES: stall = 1, and the counter increments each edge.
  - When counter == WAIT_STATES: stall = 0. The access is performed at that edge, FSM -> IDLE, counter = 0, and done pulses next cycle.
  - Total request-hold time is WAIT_STATES + 1 cycles.
- Request withdrawn while in WAIT (illegal usage): return to IDLE on the next edge, no access, no done.
- Back-to-back requests: IDLE accepts a new request in the cycle immediately after completion.
- Legality check (evaluated at the performing edge):
  - Illegal if size == 11.
  - Illegal if misaligned: halfword with adr[0] != 0, or word with adr[1:0] != 00.
  - Illegal if out of range: adr < ADDR_BASE, or adr + bytes - 1 > ADDR_BASE + DEPTH_BYTES - 1.
  - The range check uses 33-bit arithmetic so no wrap-around occurs.
- Illegal access handling:
  - No memory write.
  - rdata = 0 if it was a read; rdata is unchanged if it was a write.
  - err = 1 together with done.
- Read data format:
  - Word: {m[i], m[i+1], m[i+2], m[i+3]}.
  - Halfword: {m[i], m[i+1]} in bits [15:0].
  - Byte: m[i] in bits [7:0].
  - Upper bits are filled with the sign bit when sign_ext = 1, otherwise 0.
  - rdata holds its value until the next completed read.
- Write data placement:
  - Word: m[i..i+3] = data_in[31:0], big-endian.
  - Halfword: m[i] = data_in[15:8], m[i+1] = data_in[7:0].
  - Byte: m[i] = data_in[7:0].
  - Untouched bytes keep their values.
- Reset mid-access: the FSM aborts immediately, no write occurs, and done does not pulse.

Test Plan:
- W=0: write word 0x11223344 @1024, then read word @1024 -> rdata = 0x11223344, done one cycle after each request; read byte @1025 sign_ext=0 -> 0x00000022.
- Sign extension: write byte 0x80 @1030, read byte sign_ext=1 -> 0xFFFFFF80; read halfword @1030 sign_ext=0 -> 0x000080xx, where xx is the previous content of byte @1031.
- Errors: word read @1026 -> err=1, rdata=0. Write @1023 -> err=1, memory unchanged. Word @2044 -> ok. Word @2045 -> err. size=11 -> err.
- WAIT_STATES=3: read request -> stall high for exactly 3 cycles, done in the cycle after stall falls; immediate second request is accepted without a gap.
- Read and write asserted together @1024 -> read data returned; a later read shows the memory unchanged.
- Assert rst low during WAIT of a write -> outputs 0 asynchronously, no done; a following read shows the old data.

Source files
------------

// File: rtl/data_mem_ctrl_if.sv
// Request/response bundle between the MEM stage and the data memory.
// The MEM stage (master) drives the request fields and holds them while
// stall is high; the memory (slave) returns read data and status pulses.
interface data_mem_ctrl_if;
  logic        mem_r_en;
  logic        mem_w_en;
  logic [1:0]  size;
  logic        sign_ext;
  logic [31:0] adr;
  logic [31:0] data_in;
  logic [31:0] rdata;
  logic        done;
  logic        stall;
  logic        err;

  modport master (
    output mem_r_en, mem_w_en, size, sign_ext, adr, data_in,
    input  rdata, done, stall, err
  );

  modport slave (
    input  mem_r_en, mem_w_en, size, sign_ext, adr, data_in,
    output rdata, done, stall, err
  );
endinterface

// File: rtl/data_mem_ctrl.sv
// Data memory for the MEM stage: byte-addressed, big-endian, with
// byte/halfword/word access, sign extension, alignment/range checking and
// a configurable number of wait states signalled through stall.
//
// Storage is split into four byte lanes so that any legal (aligned) access
// touches exactly one row, which lets each lane map onto a simple block RAM
// with one write port and one registered read port. Lane k holds the bytes
// whose local index has index[1:0] == k. ADDR_BASE is expected to be a
// multiple of four so that address alignment and lane alignment coincide.
module data_mem_ctrl #(
  parameter logic [31:0] ADDR_BASE   = 32'd1024,
  parameter int unsigned DEPTH_BYTES = 1024,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic            clk,
  input  logic            rst,
  data_mem_ctrl_if.slave  bus
);

  localparam int unsigned IDX_W  = $clog2(DEPTH_BYTES);
  localparam int unsigned ROWS   = DEPTH_BYTES / 4;
  localparam int unsigned ROW_W  = (IDX_W > 2) ? IDX_W - 2 : 1;
  localparam logic [32:0] BASE33 = {1'b0, ADDR_BASE};
  localparam logic [32:0] LAST33 = BASE33 + 33'(DEPTH_BYTES) - 33'd1;
  localparam logic [3:0]  WS     = 4'(WAIT_STATES);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [3:0]      r_cnt;
  logic [3:0]      w_cnt_next;

  logic            w_req;
  logic            w_is_read;
  logic            w_is_write;
  logic            w_stall;
  logic            w_perform;

  logic [32:0]     w_adr33;
  logic [32:0]     w_nbytes;
  logic            w_bad_size;
  logic            w_misalign;
  logic            w_oor;
  logic            w_illegal;
  logic [IDX_W-1:0] w_idx;
  logic [1:0]      w_lane;
  logic [ROW_W-1:0] w_row;

  logic            r_done;
  logic            r_err;
  logic            r_rd_zero;
  logic [1:0]      r_rd_lane;
  logic [1:0]      r_rd_size;
  logic            r_rd_sign;

  logic [3:0][7:0] w_q;
  logic [7:0]      w_sel8;
  logic [15:0]     w_sel16;
  logic [31:0]     w_rdata;

  // Read wins when both enables are set, so a write needs r_en low.
  assign w_req      = bus.mem_r_en | bus.mem_w_en;
  assign w_is_read  = bus.mem_r_en;
  assign w_is_write = bus.mem_w_en & ~bus.mem_r_en;

  // Local byte index; only its low bits select lane and row.
  assign w_adr33 = {1'b0, bus.adr};
  assign w_idx   = IDX_W'(bus.adr - ADDR_BASE);
  assign w_lane  = w_idx[1:0];
  assign w_row   = ROW_W'(w_idx >> 2);

  // Legality of the presented access (size, alignment, 33-bit range check).
  always_comb begin
    w_nbytes = 33'd1;
    case (bus.size)
      2'b01:   w_nbytes = 33'd2;
      2'b10:   w_nbytes = 33'd4;
      default: w_nbytes = 33'd1;
    endcase
    w_bad_size = (bus.size == 2'b11);
    w_misalign = ((bus.size == 2'b01) && bus.adr[0]) ||
                 ((bus.size == 2'b10) && (bus.adr[1:0] != 2'b00));
    w_oor      = (w_adr33 < BASE33) || ((w_adr33 + w_nbytes - 33'd1) > LAST33);
    w_illegal  = w_bad_size | w_misalign | w_oor;
  end

  // FSM state and wait counter; reset aborts any access in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // Next state: enter WAIT on a request when wait states exist, leave it on
  // completion or when the requester drops the request.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_req && (WS != 4'd0)) begin
          w_state_next = S_WAIT;
          w_cnt_next   = 4'd1;
        end
      end
      S_WAIT: begin
        if (!w_req || (r_cnt == WS)) begin
          w_state_next = S_IDLE;
          w_cnt_next   = 4'd0;
        end else begin
          w_cnt_next   = r_cnt + 4'd1;
        end
      end
      default: begin
        w_state_next = S_IDLE;
        w_cnt_next   = 4'd0;
      end
    endcase
  end

  // Outputs of the FSM: stall while waiting, perform on the completing edge.
  // Both are held low during reset so nothing is written and upstream is free.
  always_comb begin
    w_stall   = 1'b0;
    w_perform = 1'b0;
    if (rst && w_req) begin
      case (r_state)
        S_IDLE: begin
          if (WS == 4'd0) w_perform = 1'b1;
          else            w_stall   = 1'b1;
        end
        S_WAIT: begin
          if (r_cnt == WS) w_perform = 1'b1;
          else             w_stall   = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Status pulses and the read-formatting context captured with each read.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_rd_zero <= 1'b1;
      r_rd_lane <= 2'b00;
      r_rd_size <= 2'b00;
      r_rd_sign <= 1'b0;
    end else begin
      r_done <= w_perform;
      r_err  <= w_perform & w_illegal;
      if (w_perform && w_is_read) begin
        r_rd_zero <= w_illegal;
        r_rd_lane <= w_lane;
        r_rd_size <= bus.size;
        r_rd_sign <= bus.sign_ext;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      localparam logic [1:0] LANE = 2'(gi);
      logic [7:0] r_bank [0:ROWS-1];
      logic [7:0] r_q;
      logic       w_we;
      logic [7:0] w_wd;

      // Byte enable and data for this lane, big-endian placement.
      always_comb begin
        w_we = 1'b0;
        w_wd = bus.data_in[7:0];
        case (bus.size)
          2'b10: begin
            w_we = 1'b1;
            w_wd = bus.data_in[31-8*gi -: 8];
          end
          2'b01: begin
            w_we = (w_lane[1] == LANE[1]);
            w_wd = LANE[0] ? bus.data_in[7:0] : bus.data_in[15:8];
          end
          2'b00: w_we = (w_lane == LANE);
          default: w_we = 1'b0;
        endcase
      end

      // Lane storage: write on a legal completing write, registered read on
      // a legal completing read (the output holds until the next read).
      always_ff @(posedge clk) begin
        if (w_perform && w_is_write && !w_illegal && w_we)
          r_bank[w_row] <= w_wd;
        if (w_perform && w_is_read && !w_illegal)
          r_q <= r_bank[w_row];
      end

      assign w_q[gi] = r_q;
    end
  endgenerate

  // Select, align and extend the last read; illegal reads return zero.
  always_comb begin
    w_sel8  = w_q[r_rd_lane];
    w_sel16 = r_rd_lane[1] ? {w_q[2], w_q[3]} : {w_q[0], w_q[1]};
    w_rdata = 32'd0;
    if (!r_rd_zero) begin
      case (r_rd_size)
        2'b10:   w_rdata = {w_q[0], w_q[1], w_q[2], w_q[3]};
        2'b01:   w_rdata = {{16{r_rd_sign & w_sel16[15]}}, w_sel16};
        default: w_rdata = {{24{r_rd_sign & w_sel8[7]}}, w_sel8};
      endcase
    end
  end

  assign bus.rdata = w_rdata;
  assign bus.done  = r_done;
  assign bus.err   = r_err;
  assign bus.stall = w_stall;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench: one zero-wait-state instance and one three-wait-state
// instance, exercised through per-feature tasks.
module tb_data_mem_ctrl;

  logic clk = 1'b0;
  logic rst0;
  logic rst3;
  int   checks = 0;
  int   errors = 0;

  data_mem_ctrl_if bus0 ();
  data_mem_ctrl_if bus3 ();

  data_mem_ctrl #(.ADDR_BASE(32'd1024), .DEPTH_BYTES(1024), .WAIT_STATES(0)) dut0 (
    .clk (clk),
    .rst (rst0),
    .bus (bus0)
  );

  data_mem_ctrl #(.ADDR_BASE(32'd1024), .DEPTH_BYTES(1024), .WAIT_STATES(3)) dut3 (
    .clk (clk),
    .rst (rst3),
    .bus (bus3)
  );

  always #5 clk = ~clk;

  // One access on the zero-wait instance; returns stall seen before the edge
  // and the status/data observed just after the performing edge.
  task automatic acc0(input logic r, input logic w, input logic [1:0] sz,
                      input logic sx, input logic [31:0] a, input logic [31:0] d,
                      output logic st, output logic dn, output logic er,
                      output logic [31:0] rd);
    @(negedge clk);
    bus0.mem_r_en = r; bus0.mem_w_en = w; bus0.size = sz;
    bus0.sign_ext = sx; bus0.adr = a; bus0.data_in = d;
    #1 st = bus0.stall;
    @(posedge clk);
    #1;
    dn = bus0.done; er = bus0.err; rd = bus0.rdata;
    bus0.mem_r_en = 1'b0; bus0.mem_w_en = 1'b0;
    $display("dut0 r=%0b w=%0b sz=%0d sx=%0b adr=%0d din=%h -> done=%0b err=%0b rdata=%h",
             r, w, sz, sx, a, d, dn, er, rd);
  endtask

  // One access on the wait-state instance; counts cycles with stall high
  // (bounded) and reports done as seen in the last stalled-free cycle.
  task automatic acc3(input bit nowait, input logic r, input logic w,
                      input logic [1:0] sz, input logic sx,
                      input logic [31:0] a, input logic [31:0] d,
                      output int cnt, output logic pre_dn, output logic dn,
                      output logic er, output logic [31:0] rd);
    if (!nowait) @(negedge clk);
    bus3.mem_r_en = r; bus3.mem_w_en = w; bus3.size = sz;
    bus3.sign_ext = sx; bus3.adr = a; bus3.data_in = d;
    #1;
    cnt = 0;
    while (bus3.stall === 1'b1 && cnt < 20) begin
      cnt++;
      @(posedge clk);
      #1;
    end
    pre_dn = bus3.done;
    @(posedge clk);
    #1;
    dn = bus3.done; er = bus3.err; rd = bus3.rdata;
    bus3.mem_r_en = 1'b0; bus3.mem_w_en = 1'b0;
    $display("dut3 r=%0b w=%0b sz=%0d adr=%0d din=%h -> stall_cycles=%0d done=%0b err=%0b rdata=%h",
             r, w, sz, a, d, cnt, dn, er, rd);
  endtask

  task automatic test_reset;
    rst0 = 1'b0; rst3 = 1'b0;
    bus0.mem_r_en = 1'b1; bus0.mem_w_en = 1'b0; bus0.size = 2'b10;
    bus0.sign_ext = 1'b0; bus0.adr = 32'd1024; bus0.data_in = 32'd0;
    bus3.mem_r_en = 1'b1; bus3.mem_w_en = 1'b0; bus3.size = 2'b10;
    bus3.sign_ext = 1'b0; bus3.adr = 32'd1024; bus3.data_in = 32'd0;
    #12;
    checks++; if (bus0.rdata !== 32'd0) begin errors++; $display("FAIL reset_rdata0 got %h exp 0", bus0.rdata); end
    checks++; if (bus0.done !== 1'b0) begin errors++; $display("FAIL reset_done0 got %b exp 0", bus0.done); end
    checks++; if (bus0.err !== 1'b0) begin errors++; $display("FAIL reset_err0 got %b exp 0", bus0.err); end
    checks++; if (bus3.stall !== 1'b0) begin errors++; $display("FAIL reset_stall3 got %b exp 0", bus3.stall); end
    checks++; if (bus3.done !== 1'b0) begin errors++; $display("FAIL reset_done3 got %b exp 0", bus3.done); end
    checks++; if (bus3.rdata !== 32'd0) begin errors++; $display("FAIL reset_rdata3 got %h exp 0", bus3.rdata); end
    bus0.mem_r_en = 1'b0; bus3.mem_r_en = 1'b0;
    @(negedge clk);
    rst0 = 1'b1; rst3 = 1'b1;
  endtask

  task automatic test_word_rw;
    logic st, dn, er; logic [31:0] rd;
    acc0(1'b0, 1'b1, 2'b10, 1'b0, 32'd1024, 32'h11223344, st, dn, er, rd);
    checks++; if (dn !== 1'b1 || er !== 1'b0 || st !== 1'b0) begin errors++; $display("FAIL wr_word done/err/stall got %b/%b/%b exp 1/0/0", dn, er, st); end
    @(posedge clk); #1;
    checks++; if (bus0.done !== 1'b0) begin errors++; $display("FAIL done_pulse got %b exp 0", bus0.done); end
    acc0(1'b1, 1'b0, 2'b10, 1'b0, 32'd1024, 32'd0, st, dn, er, rd);
    checks++; if (rd !== 32'h11223344 || dn !== 1'b1 || st !== 1'b0) begin errors++; $display("FAIL rd_word got %h done=%b exp 11223344 done=1", rd, dn); end
    acc0(1'b1, 1'b0, 2'b00, 1'b0, 32'd1025, 32'd0, st, dn, er, rd);
    checks++; if (rd !== 32'h00000022) begin errors++; $display("FAIL rd_byte1025 got %h exp 00000022", rd); end
  endtask

  task automatic test_sign_ext;
    logic st, dn, er; logic [31:0] rd;
    acc0(1'b0, 1'b1, 2'b10, 1'b0, 32'd1028, 32'hA5A5A5A5, st, dn, er, rd);
    acc0(1'b0, 1'b1, 2'b00, 1'b0, 32'd1030, 32'h12345680, st, dn, er, rd);
    checks++; if (er !== 1'b0 || dn !== 1'b1) begin errors++; $display("FAIL wr_byte1030 err/done got %b/%b exp 0/1", er, dn); end
    acc0(1'b1, 1'b0, 2'b00, 1'b1, 32'd1030, 32'd0, st, dn, er, rd);
    checks++; if (rd !== 32'hFFFFFF80) begin errors++; $display("FAIL rd_byte_sx got %h exp ffffff80", rd); end
    acc0(1'b1, 1'b0, 2'b01, 1'b0, 32'd1030, 32'd0, st, dn, er, rd);
    checks++; if (rd !== 32'h000080A5) begin errors++; $display("FAIL rd_half_zx got %h exp 000080a5", rd); end
    acc0(1'b1, 1'b0, 2'b01, 1'b1, 32'd1028, 32'd0, st, dn, er, rd);
    checks++; if (rd !== 32'hFFFFA5A5) begin errors++; $display("FAIL rd_half_sx got %h exp ffffa5a5", rd); end
    acc0(1'b0, 1'b1, 2'b01, 1'b0, 32'd1032, 32'hFFFF7F01, st, dn, er, rd);
    acc0(1'b1, 1'b0, 2'b01, 1'b1, 32'd1032, 32'd0, st, dn, er, rd);
    checks++; if (rd !== 32'h00007F01) begin errors++; $display("FAIL rd_half_pos got %h exp 00007f01", rd); end
    acc0(1'b1, 1'b0, 2'b00, 1'b1, 32'd1033, 32'd0, st, dn, er, rd);
    checks++; if (rd !== 32'h00000001) begin errors++; $display("FAIL rd_byte1033 got %h exp 00000001", rd); end
  endtask

  task automatic test_errors;
    logic st, dn, er; logic [31:0] rd;
    acc0(1'b1, 1'b0, 2'b10, 1'b0, 32'd1026, 32'd0, st, dn, er, rd);
    checks++; if (er !== 1'b1 || dn !== 1'b1 || rd !== 32'd0) begin errors++; $display("FAIL misalign_word err=%b done=%b rdata=%h exp 1/1/0", er, dn, rd); end
    acc0(1'b1, 1'b0, 2'b00, 1'b0, 32'd1024, 32'd0, st, dn, er, rd);
    checks++; if (rd !== 32'h00000011 || er !== 1'b0) begin errors++; $display("FAIL rd_byte1024 got %h err=%b exp 00000011 err=0", rd, er); end
    acc0(1'b0, 1'b1, 2'b00, 1'b0, 32'd1023, 32'h00000055, st, dn, er, rd);
    checks++; if (er !== 1'b1 || rd !== 32'h00000011) begin errors++; $display("FAIL wr_below err=%b rdata=%h exp 1/00000011", er, rd); end
    acc0(1'b1, 1'b0, 2'b10, 1'b0, 32'd1024, 32'd0, st, dn, er, rd);
    checks++; if (rd !== 32'h11223344) begin errors++; $display("FAIL mem_after_bad_wr got %h exp 11223344", rd); end
    acc0(1'b0, 1'b1, 2'b10, 1'b0, 32'd2044, 32'h01020304, st, dn, er, rd);
    checks++; if (er !== 1'b0) begin errors++; $display("FAIL wr_top_word err got %b exp 0", er); end
    acc0(1'b1, 1'b0, 2'b10, 1'b0, 32'd2044, 32'd0, st, dn, er, rd);
    checks++; if (rd !== 32'h01020304 || er !== 1'b0) begin errors++; $display("FAIL rd_top_word got %h err=%b exp 01020304 err=0", rd, er); end
    acc0(1'b1, 1'b0, 2'b10, 1'b0, 32'd2045, 32'd0, st, dn, er, rd);
    checks++; if (er !== 1'b1 || rd !== 32'd0) begin errors++; $display("FAIL rd_2045 err=%b rdata=%h exp 1/0", er, rd); end
    acc0(1'b1, 1'b0, 2'b00, 1'b0, 32'd2047, 32'd0, st, dn, er, rd);
    checks++; if (er !== 1'b0 || rd !== 32'h00000004) begin errors++; $display("FAIL rd_last_byte err=%b rdata=%h exp 0/00000004", er, rd); end
    acc0(1'b1, 1'b0, 2'b11, 1'b0, 32'd1024, 32'd0, st, dn, er, rd);
    checks++; if (er !== 1'b1 || dn !== 1'b1) begin errors++; $display("FAIL size11 err=%b done=%b exp 1/1", er, dn); end
    acc0(1'b1, 1'b0, 2'b01, 1'b0, 32'd1025, 32'd0, st, dn, er, rd);
    checks++; if (er !== 1'b1) begin errors++; $display("FAIL misalign_half err got %b exp 1", er); end
  endtask

  task automatic test_rw_priority;
    logic st, dn, er; logic [31:0] rd;
    acc0(1'b1, 1'b1, 2'b10, 1'b0, 32'd1024, 32'hFFFFFFFF, st, dn, er, rd);
    checks++; if (rd !== 32'h11223344 || er !== 1'b0) begin errors++; $display("FAIL rw_both got %h err=%b exp 11223344 err=0", rd, er); end
    acc0(1'b1, 1'b0, 2'b10, 1'b0, 32'd1024, 32'd0, st, dn, er, rd);
    checks++; if (rd !== 32'h11223344) begin errors++; $display("FAIL rw_both_mem got %h exp 11223344", rd); end
  endtask

  task automatic test_wait_states;
    int cnt; logic pre_dn, dn, er; logic [31:0] rd;
    acc3(1'b0, 1'b0, 1'b1, 2'b10, 1'b0, 32'd1024, 32'hCAFEF00D, cnt, pre_dn, dn, er, rd);
    checks++; if (cnt !== 3) begin errors++; $display("FAIL ws_wr_stall_cycles got %0d exp 3", cnt); end
    checks++; if (pre_dn !== 1'b0 || dn !== 1'b1 || er !== 1'b0) begin errors++; $display("FAIL ws_wr_done pre=%b done=%b err=%b exp 0/1/0", pre_dn, dn, er); end
    acc3(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'd1024, 32'd0, cnt, pre_dn, dn, er, rd);
    checks++; if (cnt !== 3) begin errors++; $display("FAIL ws_b2b_stall_cycles got %0d exp 3", cnt); end
    checks++; if (pre_dn !== 1'b0 || dn !== 1'b1 || rd !== 32'hCAFEF00D) begin errors++; $display("FAIL ws_b2b_read pre=%b done=%b rdata=%h exp 0/1/cafef00d", pre_dn, dn, rd); end
  endtask

  task automatic test_reset_mid_access;
    int cnt; logic pre_dn, dn, er; logic [31:0] rd;
    @(negedge clk);
    bus3.mem_r_en = 1'b0; bus3.mem_w_en = 1'b1; bus3.size = 2'b10;
    bus3.sign_ext = 1'b0; bus3.adr = 32'd1024; bus3.data_in = 32'hDEADBEEF;
    @(posedge clk); #1;
    checks++; if (bus3.stall !== 1'b1) begin errors++; $display("FAIL mid_stall got %b exp 1", bus3.stall); end
    rst3 = 1'b0;
    #1;
    checks++; if (bus3.stall !== 1'b0 || bus3.rdata !== 32'd0 || bus3.done !== 1'b0 || bus3.err !== 1'b0)
      begin errors++; $display("FAIL mid_reset_outs stall=%b rdata=%h done=%b err=%b exp 0/0/0/0", bus3.stall, bus3.rdata, bus3.done, bus3.err); end
    @(posedge clk); #1;
    checks++; if (bus3.done !== 1'b0) begin errors++; $display("FAIL mid_reset_done got %b exp 0", bus3.done); end
    bus3.mem_w_en = 1'b0;
    @(negedge clk);
    rst3 = 1'b1;
    @(posedge clk); #1;
    checks++; if (bus3.done !== 1'b0) begin errors++; $display("FAIL post_reset_done got %b exp 0", bus3.done); end
    acc3(1'b0, 1'b1, 1'b0, 2'b10, 1'b0, 32'd1024, 32'd0, cnt, pre_dn, dn, er, rd);
    checks++; if (rd !== 32'hCAFEF00D || cnt !== 3) begin errors++; $display("FAIL post_reset_read got %h cycles=%0d exp cafef00d/3", rd, cnt); end
  endtask

  initial begin
    test_reset();
    test_word_rw();
    test_sign_ext();
    test_errors();
    test_rw_priority();
    test_wait_states();
    test_reset_mid_access();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
